// File: rtl/tmds_decoder.sv
// One-channel DVI TMDS receive decoder: word alignment by control-token hunting with
// bitslip feedback to the deserializer, then 2-stage decode to DE / {C1,C0} / pixel byte.
//
// state  | meaning
// SEARCH | hunting for LOCK_RUN consecutive control tokens; slip on long token-free gap
// SLIP   | bitslip issued, waiting SLIP_WAIT cycles for the deserializer to settle
// LOCKED | aligned; outputs enabled; a long token-free gap drops back to SEARCH
module tmds_decoder #(
  parameter int LOCK_RUN       = 64,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 8
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic [9:0] i_tmds,
  output logic       o_bitslip,
  output logic       o_locked,
  output logic       o_err,
  output logic       o_de,
  output logic [1:0] o_c,
  output logic [7:0] o_data
);

  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int IDLE_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_RUN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SEARCH_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Reset asserts asynchronously, releases two clocks after rst_n rises.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic       tok_hit;
  logic [1:0] tok_val;

  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    case (i_tmds)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: tok_hit = 1'b0;
    endcase
  end

  logic [9:0] tmds_q;
  logic       ctrl_q;
  logic [1:0] cval_q;

  always_ff @(posedge pixclk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      tmds_q <= 10'd0;
      ctrl_q <= 1'b0;
      cval_q <= 2'b00;
    end else begin
      tmds_q <= i_tmds;
      ctrl_q <= tok_hit;
      cval_q <= tok_val;
    end
  end

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [SLIP_W-1:0]   slip_q, slip_d;
  logic                bitslip_q, bitslip_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;

  logic [RUN_W-1:0]    run_inc;
  logic [IDLE_W-1:0]   idle_inc;
  logic                timeout;
  logic                run_hit;
  logic                slip_done;

  // A token on the timeout cycle wins: timeout needs a non-token word.
  always_comb begin
    run_inc   = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    idle_inc  = (idle_q >= IDLE_MAX) ? IDLE_MAX : idle_q + 1'b1;
    timeout   = !ctrl_q && (idle_q >= IDLE_LAST);
    run_hit   = ctrl_q && (run_q >= RUN_LAST);
    slip_done = (slip_q >= SLIP_LAST);
  end

  always_ff @(posedge pixclk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      idle_q    <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      idle_q    <= idle_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (timeout)      state_d = ST_SLIP;
        else if (run_hit) state_d = ST_LOCKED;
      end
      ST_SLIP: begin
        if (slip_done) state_d = ST_SEARCH;
      end
      ST_LOCKED: begin
        if (timeout) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    run_d     = ctrl_q ? run_inc : '0;
    idle_d    = ctrl_q ? '0 : idle_inc;
    slip_d    = '0;
    bitslip_d = 1'b0;
    err_d     = 1'b0;
    locked_d  = (state_d == ST_LOCKED);
    case (state_q)
      ST_SEARCH: begin
        if (timeout) begin
          bitslip_d = 1'b1;
          run_d     = '0;
          idle_d    = '0;
        end
      end
      ST_SLIP: begin
        run_d  = '0;
        idle_d = '0;
        slip_d = slip_done ? '0 : slip_q + 1'b1;
      end
      ST_LOCKED: begin
        if (timeout) begin
          err_d  = 1'b1;
          run_d  = '0;
          idle_d = '0;
        end
      end
      default: begin
        run_d  = '0;
        idle_d = '0;
      end
    endcase
  end

  logic [7:0] d_pre;
  logic [7:0] dec;

  always_comb begin
    d_pre  = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    dec    = 8'd0;
    dec[0] = d_pre[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = tmds_q[8] ? (d_pre[i] ^ d_pre[i-1]) : ~(d_pre[i] ^ d_pre[i-1]);
    end
  end

  logic       de_q;
  logic [1:0] c_q;
  logic [7:0] data_q;

  // Gate with the lock flag that becomes visible on this same edge.
  always_ff @(posedge pixclk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      de_q   <= 1'b0;
      c_q    <= 2'b00;
      data_q <= 8'd0;
    end else if (!locked_d) begin
      de_q   <= 1'b0;
      c_q    <= 2'b00;
      data_q <= 8'd0;
    end else if (ctrl_q) begin
      de_q   <= 1'b0;
      c_q    <= cval_q;
      data_q <= 8'd0;
    end else begin
      de_q   <= 1'b1;
      data_q <= dec;
    end
  end

  assign o_bitslip = bitslip_q;
  assign o_locked  = locked_q;
  assign o_err     = err_q;
  assign o_de      = de_q;
  assign o_c       = c_q;
  assign o_data    = data_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: directed words with hand-decoded expectations,
// plus timing checks on lock, bitslip and loss-of-lock events.
module tb_tmds_decoder;

  localparam int LOCK_RUN       = 64;
  localparam int SEARCH_TIMEOUT = 4096;
  localparam int SLIP_WAIT      = 8;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic [9:0] i_tmds = 10'h200;
  logic       o_bitslip, o_locked, o_err, o_de;
  logic [1:0] o_c;
  logic [7:0] o_data;

  tmds_decoder #(
    .LOCK_RUN(LOCK_RUN), .SEARCH_TIMEOUT(SEARCH_TIMEOUT), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .pixclk(pixclk), .rst_n(rst_n), .i_tmds(i_tmds),
    .o_bitslip(o_bitslip), .o_locked(o_locked), .o_err(o_err),
    .o_de(o_de), .o_c(o_c), .o_data(o_data)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    int          due;
    int          scen;
    int          idx;
    logic [10:0] v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_drv = 0;
  int   scen     = 0;
  int   widx     = 0;
  int   slip_cyc[$];
  int   err_cyc[$];
  int   lock_cyc[$];
  int   unlock_cyc[$];
  logic prev_locked = 1'b0;

  task automatic check_v(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ev(input logic de, input logic [1:0] c, input logic [7:0] d);
    return {de, c, d};
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  always @(posedge pixclk) cyc++;

  // Monitor: event logging and scoreboard pop, sampled 1 time unit after the edge.
  always @(posedge pixclk) begin
    #1;
    if (o_bitslip) slip_cyc.push_back(cyc);
    if (o_err) err_cyc.push_back(cyc);
    if (o_locked && !prev_locked) lock_cyc.push_back(cyc);
    if (!o_locked && prev_locked) unlock_cyc.push_back(cyc);
    prev_locked = o_locked;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.due != cyc)
        check_v($sformatf("sb_s%0d_w%0d_late", mon_e.scen, mon_e.idx), cyc, mon_e.due);
      else
        check_v($sformatf("sb_s%0d_w%0d", mon_e.scen, mon_e.idx), {o_de, o_c, o_data}, mon_e.v);
    end
  end

  task automatic drive(input logic [9:0] w, input bit chk, input logic [10:0] v);
    exp_t e;
    @(negedge pixclk);
    i_tmds   = w;
    last_drv = cyc;
    if (chk) begin
      e.due  = cyc + 2;
      e.scen = scen;
      e.idx  = widx;
      e.v    = v;
      sb_q.push_back(e);
    end
    widx++;
  endtask

  task automatic pulse_reset();
    @(negedge pixclk);
    rst_n = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge pixclk);
    rst_n = 1'b1;
  endtask

  // Aligned 10'h354 stream from SEARCH: lock exactly LOCK_RUN+1 cycles after the first token.
  task automatic run_lock(input string tag);
    int c0;
    repeat (4) drive(10'h200, 1'b0, 11'd0);
    slip_cyc.delete();
    lock_cyc.delete();
    for (int i = 0; i < LOCK_RUN + 10; i++) begin
      drive(10'h354, 1'b1, ev(1'b0, 2'b00, 8'h00));
      if (i == 0) c0 = last_drv;
    end
    check_v({tag, "_locked"}, o_locked, 1);
    check_v({tag, "_lock_events"}, lock_cyc.size(), 1);
    if (lock_cyc.size() > 0) check_v({tag, "_lock_latency"}, lock_cyc[0] - c0, LOCK_RUN + 1);
    check_v({tag, "_no_slip"}, slip_cyc.size(), 0);
  endtask

  initial begin
    int t_unlock;
    int t_slip;
    int r;
    logic [10:0] s3_exp [8];
    logic [9:0]  s3_w   [8];

    #2 rst_n = 1'b0;
    repeat (2) @(negedge pixclk);
    check_v("rst_locked", o_locked, 0);
    check_v("rst_bitslip", o_bitslip, 0);
    check_v("rst_err", o_err, 0);
    check_v("rst_de", o_de, 0);
    check_v("rst_c", o_c, 0);
    check_v("rst_data", o_data, 0);
    rst_n = 1'b1;

    scen = 1;
    run_lock("s1");

    // Decode: data words, each control token, and both XOR/XNOR + invert paths.
    scen = 3;
    s3_w = '{10'h100, 10'h200, 10'h0AB, 10'h2AB, 10'h154, 10'h1A5, 10'h2A5, 10'h354};
    s3_exp = '{ev(1'b1, 2'b00, 8'h00), ev(1'b1, 2'b00, 8'hFF), ev(1'b0, 2'b01, 8'h00),
               ev(1'b0, 2'b11, 8'h00), ev(1'b0, 2'b10, 8'h00), ev(1'b1, 2'b10, 8'hEF),
               ev(1'b1, 2'b10, 8'h10), ev(1'b0, 2'b00, 8'h00)};
    for (int i = 0; i < 8; i++) drive(s3_w[i], 1'b1, s3_exp[i]);

    // Loss of lock after exactly SEARCH_TIMEOUT token-free words.
    scen = 4;
    err_cyc.delete();
    unlock_cyc.delete();
    for (int k = 1; k <= SEARCH_TIMEOUT; k++) begin
      if (k == SEARCH_TIMEOUT - 1)  drive(10'h200, 1'b1, ev(1'b1, 2'b00, 8'hFF));
      else if (k == SEARCH_TIMEOUT) drive(10'h200, 1'b1, ev(1'b0, 2'b00, 8'h00));
      else                          drive(10'h200, 1'b0, 11'd0);
    end
    t_unlock = last_drv + 2;
    repeat (8) drive(10'h200, 1'b1, ev(1'b0, 2'b00, 8'h00));
    repeat (4) drive(10'h354, 1'b1, ev(1'b0, 2'b00, 8'h00));
    check_v("s4_locked", o_locked, 0);
    check_v("s4_err_count", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check_v("s4_err_cycle", err_cyc[0], t_unlock);
    check_v("s4_unlock_count", unlock_cyc.size(), 1);
    if (unlock_cyc.size() > 0) check_v("s4_unlock_cycle", unlock_cyc[0], t_unlock);
    check_v("s4_no_slip_locked", slip_cyc.size(), 0);

    // Token on the timeout cycle in SEARCH wins; the next full gap slips exactly on time.
    scen = 5;
    slip_cyc.delete();
    drive(10'h354, 1'b0, 11'd0);
    repeat (SEARCH_TIMEOUT - 1) drive(10'h200, 1'b0, 11'd0);
    drive(10'h354, 1'b0, 11'd0);
    repeat (SEARCH_TIMEOUT - 1) drive(10'h200, 1'b0, 11'd0);
    check_v("s5_no_slip_on_token", slip_cyc.size(), 0);
    drive(10'h200, 1'b0, 11'd0);
    t_slip = last_drv + 2;
    repeat (3) drive(10'h200, 1'b0, 11'd0);
    check_v("s5_slip_count", slip_cyc.size(), 1);
    if (slip_cyc.size() > 0) check_v("s5_slip_cycle", slip_cyc[0], t_slip);
    check_v("s5_no_err", err_cyc.size(), 1);

    // Stream misaligned by 3 bits; deserializer model rotates back one bit per slip.
    scen = 2;
    pulse_reset();
    repeat (4) drive(10'h200, 1'b0, 11'd0);
    slip_cyc.delete();
    err_cyc.delete();
    r = 3;
    for (int n = 0; n < 20000 && !o_locked; n++) begin
      @(negedge pixclk);
      if (o_bitslip) r = (r + 9) % 10;
      i_tmds = rotl(10'h354, r);
    end
    check_v("s2_locked", o_locked, 1);
    check_v("s2_slip_count", slip_cyc.size(), 3);
    check_v("s2_final_rot", r, 0);
    if (slip_cyc.size() >= 3) begin
      check_v("s2_spacing1", slip_cyc[1] - slip_cyc[0], SEARCH_TIMEOUT + SLIP_WAIT);
      check_v("s2_spacing2", slip_cyc[2] - slip_cyc[1], SEARCH_TIMEOUT + SLIP_WAIT);
    end
    check_v("s2_no_err", err_cyc.size(), 0);

    // Reset mid-line while locked, then relock.
    scen = 6;
    repeat (2) drive(10'h354, 1'b0, 11'd0);
    repeat (3) drive(10'h200, 1'b1, ev(1'b1, 2'b00, 8'hFF));
    repeat (2) drive(10'h200, 1'b0, 11'd0);
    check_v("s6_de_before", o_de, 1);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_v("s6_rst_locked", o_locked, 0);
    check_v("s6_rst_de", o_de, 0);
    check_v("s6_rst_c", o_c, 0);
    check_v("s6_rst_data", o_data, 0);
    check_v("s6_rst_bitslip", o_bitslip, 0);
    check_v("s6_rst_err", o_err, 0);
    repeat (3) @(negedge pixclk);
    rst_n = 1'b1;
    run_lock("s6");

    repeat (4) drive(10'h354, 1'b0, 11'd0);
    check_v("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
